// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard control bundle: pipeline register fields in, stall/flush controls out.
interface hazard_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] ID_EX_rd;
    logic             ID_EX_memread;
    logic [REG_W-1:0] IF_ID_rs1;
    logic [REG_W-1:0] IF_ID_rs2;
    logic             IF_ID_rs1_used;
    logic             IF_ID_rs2_used;
    logic             branch_taken;
    logic             dmem_busy;
    logic             perf_clr;
    logic             PCWrite;
    logic             IF_Dwrite;
    logic             hazard_out;
    logic             if_id_flush;
    logic             pipe_freeze;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output ID_EX_rd, ID_EX_memread, IF_ID_rs1, IF_ID_rs2,
               IF_ID_rs1_used, IF_ID_rs2_used, branch_taken, dmem_busy, perf_clr,
        input  PCWrite, IF_Dwrite, hazard_out, if_id_flush, pipe_freeze, stall_cnt
    );

    modport slave (
        input  ID_EX_rd, ID_EX_memread, IF_ID_rs1, IF_ID_rs2,
               IF_ID_rs1_used, IF_ID_rs2_used, branch_taken, dmem_busy, perf_clr,
        output PCWrite, IF_Dwrite, hazard_out, if_id_flush, pipe_freeze, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Load-use stall, branch flush and memory freeze control for an in-order pipeline.
//
//   state  | meaning
//   IDLE   | no multi-cycle stall in progress; a new load-use hazard may start one
//   LSTALL | remaining load-use stall cycles pending, rem+1 of them left
module hazard_ctrl_unit #(
    parameter int REG_W    = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    hazard_ctrl_if.slave  hz
);
    typedef enum logic {IDLE, LSTALL} state_t;

    // First stall cycle is spent in IDLE, so LSTALL covers the remaining LOAD_LAT-1.
    localparam logic [2:0] REM_INIT = (LOAD_LAT > 1) ? 3'(LOAD_LAT - 2) : 3'd0;

    state_t           state;
    logic [2:0]       rem;
    logic [CNT_W-1:0] cnt_q;
    logic [REG_W-1:0] rd;
    logic             hazard;
    logic             pc_write;

    assign rd = hz.ID_EX_rd;

    // Load-use detection; x0 and unread sources never stall.
    always_comb begin
        hazard = hz.ID_EX_memread && (rd != '0) &&
                 ((hz.IF_ID_rs1_used && (rd == hz.IF_ID_rs1)) ||
                  (hz.IF_ID_rs2_used && (rd == hz.IF_ID_rs2)));
    end

    // Zero-latency control outputs: busy > branch > LSTALL > hazard > normal.
    always_comb begin
        pc_write       = 1'b1;
        hz.IF_Dwrite   = 1'b1;
        hz.hazard_out  = 1'b0;
        hz.if_id_flush = 1'b0;
        hz.pipe_freeze = 1'b0;
        if (hz.dmem_busy) begin
            pc_write       = 1'b0;
            hz.IF_Dwrite   = 1'b0;
            hz.pipe_freeze = 1'b1;
        end else if (hz.branch_taken) begin
            hz.if_id_flush = 1'b1;
            hz.hazard_out  = 1'b1;
        end else if ((state == LSTALL) || hazard) begin
            pc_write      = 1'b0;
            hz.IF_Dwrite  = 1'b0;
            hz.hazard_out = 1'b1;
        end
    end

    assign hz.PCWrite   = pc_write;
    assign hz.stall_cnt = cnt_q;

    // Stall sequencing plus saturating stall-cycle counter; frozen cycles hold the sequence.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            rem   <= 3'd0;
            cnt_q <= '0;
        end else begin
            if (hz.perf_clr) begin
                cnt_q <= '0;
            end else if (!pc_write && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (!hz.dmem_busy) begin
                if (hz.branch_taken) begin
                    state <= IDLE;
                end else if (state == LSTALL) begin
                    if (rem == 3'd0) begin
                        state <= IDLE;
                    end else begin
                        rem <= rem - 3'd1;
                    end
                end else if (hazard && (LOAD_LAT > 1)) begin
                    state <= LSTALL;
                    rem   <= REM_INIT;
                end
            end
        end
    end
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench: three instances (LOAD_LAT=1; LOAD_LAT=3; LOAD_LAT=3 with 4-bit counter)
// share one stimulus stream; expected values are hand-computed per instance.
module tb_hazard_ctrl_unit;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_W(5), .CNT_W(16)) ia ();
    hazard_ctrl_if #(.REG_W(5), .CNT_W(16)) ib ();
    hazard_ctrl_if #(.REG_W(5), .CNT_W(4))  ic ();

    hazard_ctrl_unit #(.REG_W(5), .LOAD_LAT(1), .CNT_W(16)) dut_a (.clk(clk), .reset_n(reset_n), .hz(ia));
    hazard_ctrl_unit #(.REG_W(5), .LOAD_LAT(3), .CNT_W(16)) dut_b (.clk(clk), .reset_n(reset_n), .hz(ib));
    hazard_ctrl_unit #(.REG_W(5), .LOAD_LAT(3), .CNT_W(4))  dut_c (.clk(clk), .reset_n(reset_n), .hz(ic));

    // Control vector order: {PCWrite, IF_Dwrite, hazard_out, if_id_flush, pipe_freeze}
    localparam logic [4:0] NORM   = 5'b11000;
    localparam logic [4:0] STALL  = 5'b00100;
    localparam logic [4:0] FREEZE = 5'b00001;
    localparam logic [4:0] FLUSH  = 5'b11110;

    function automatic logic [4:0] ctl_a();
        return {ia.PCWrite, ia.IF_Dwrite, ia.hazard_out, ia.if_id_flush, ia.pipe_freeze};
    endfunction
    function automatic logic [4:0] ctl_b();
        return {ib.PCWrite, ib.IF_Dwrite, ib.hazard_out, ib.if_id_flush, ib.pipe_freeze};
    endfunction
    function automatic logic [4:0] ctl_c();
        return {ic.PCWrite, ic.IF_Dwrite, ic.hazard_out, ic.if_id_flush, ic.pipe_freeze};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic u1, input logic u2,
                         input logic br, input logic busy, input logic clr);
        ia.ID_EX_memread = mr;  ib.ID_EX_memread = mr;  ic.ID_EX_memread = mr;
        ia.ID_EX_rd = rd;       ib.ID_EX_rd = rd;       ic.ID_EX_rd = rd;
        ia.IF_ID_rs1 = rs1;     ib.IF_ID_rs1 = rs1;     ic.IF_ID_rs1 = rs1;
        ia.IF_ID_rs2 = rs2;     ib.IF_ID_rs2 = rs2;     ic.IF_ID_rs2 = rs2;
        ia.IF_ID_rs1_used = u1; ib.IF_ID_rs1_used = u1; ic.IF_ID_rs1_used = u1;
        ia.IF_ID_rs2_used = u2; ib.IF_ID_rs2_used = u2; ic.IF_ID_rs2_used = u2;
        ia.branch_taken = br;   ib.branch_taken = br;   ic.branch_taken = br;
        ia.dmem_busy = busy;    ib.dmem_busy = busy;    ic.dmem_busy = busy;
        ia.perf_clr = clr;      ib.perf_clr = clr;      ic.perf_clr = clr;
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle_in();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic load_use();
        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        idle_in();
        #2;
        chk("reset_ctl_a", 16'(ctl_a()), 16'(NORM));
        chk("reset_ctl_b", 16'(ctl_b()), 16'(NORM));
        chk("reset_cnt_b", ib.stall_cnt, 16'd0);
        cyc(); reset_n = 1'b1;

        // x0 destination and unread source never stall
        cyc(); drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); #1;
        chk("x0_ctl_a", 16'(ctl_a()), 16'(NORM));
        chk("x0_ctl_b", 16'(ctl_b()), 16'(NORM));
        cyc(); drive(1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); #1;
        chk("unused_rs2_ctl_a", 16'(ctl_a()), 16'(NORM));
        chk("unused_rs2_ctl_b", 16'(ctl_b()), 16'(NORM));

        // Single load-use hazard: LOAD_LAT=1 stalls one cycle, LOAD_LAT=3 three
        cyc(); load_use(); #1;
        chk("lu_c0_ctl_a", 16'(ctl_a()), 16'(STALL));
        chk("lu_c0_ctl_b", 16'(ctl_b()), 16'(STALL));
        cyc(); idle_in(); #1;
        chk("lu_c1_ctl_a", 16'(ctl_a()), 16'(NORM));
        chk("lu_c1_cnt_a", ia.stall_cnt, 16'd1);
        chk("lu_c1_ctl_b", 16'(ctl_b()), 16'(STALL));
        cyc(); #1;
        chk("lu_c2_ctl_b", 16'(ctl_b()), 16'(STALL));
        cyc(); #1;
        chk("lu_c3_ctl_b", 16'(ctl_b()), 16'(NORM));
        chk("lu_c3_cnt_b", ib.stall_cnt, 16'd3);
        chk("lu_c3_cnt_a", ia.stall_cnt, 16'd1);

        // Clear counters, then freeze for two cycles inside LSTALL
        cyc(); drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(); idle_in(); #1;
        chk("clr_cnt_b", ib.stall_cnt, 16'd0);
        cyc(); load_use(); #1;
        chk("fz_c0_ctl_b", 16'(ctl_b()), 16'(STALL));
        cyc(); drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); #1;
        chk("fz_c1_ctl_b", 16'(ctl_b()), 16'(FREEZE));
        cyc(); #1;
        chk("fz_c2_ctl_b", 16'(ctl_b()), 16'(FREEZE));
        cyc(); idle_in(); #1;
        chk("fz_c3_ctl_b", 16'(ctl_b()), 16'(STALL));
        chk("fz_c3_ctl_a", 16'(ctl_a()), 16'(NORM));
        cyc(); #1;
        chk("fz_c4_ctl_b", 16'(ctl_b()), 16'(STALL));
        cyc(); #1;
        chk("fz_c5_ctl_b", 16'(ctl_b()), 16'(NORM));
        chk("fz_cnt_b", ib.stall_cnt, 16'd5);
        chk("fz_cnt_a", ia.stall_cnt, 16'd3);

        // Branch on the second stall cycle aborts LSTALL
        cyc(); load_use(); #1;
        chk("br_c0_ctl_b", 16'(ctl_b()), 16'(STALL));
        cyc(); drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); #1;
        chk("br_c1_ctl_b", 16'(ctl_b()), 16'(FLUSH));
        cyc(); idle_in(); #1;
        chk("br_c2_ctl_b", 16'(ctl_b()), 16'(NORM));

        // Branch while memory busy: freeze wins, flush waits until busy drops
        cyc(); drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); #1;
        chk("brbusy_ctl_a", 16'(ctl_a()), 16'(FREEZE));
        cyc(); drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); #1;
        chk("brdrop_ctl_a", 16'(ctl_a()), 16'(FLUSH));

        // Continuous hazards for 20 cycles: 4-bit counter saturates at 15
        cyc(); drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(); load_use();
        for (int i = 0; i < 19; i++) cyc();
        cyc(); drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); #1;
        chk("sat_cnt_c", 16'(ic.stall_cnt), 16'd15);
        chk("sat_cnt_b", ib.stall_cnt, 16'd20);
        chk("sat_cnt_a", ia.stall_cnt, 16'd20);
        chk("sat_ctl_b", 16'(ctl_b()), 16'(STALL));
        cyc(); idle_in(); #1;
        chk("pclr_cnt_c", 16'(ic.stall_cnt), 16'd0);
        chk("pclr_cnt_a", ia.stall_cnt, 16'd0);

        // Reset in the middle of LSTALL takes effect the same cycle
        cyc(); load_use();
        cyc(); idle_in(); #1;
        chk("prerst_ctl_b", 16'(ctl_b()), 16'(STALL));
        reset_n = 1'b0; #1;
        chk("rst_ctl_b", 16'(ctl_b()), 16'(NORM));
        chk("rst_cnt_c", 16'(ic.stall_cnt), 16'd0);
        cyc(); reset_n = 1'b1; #1;
        chk("postrst_ctl_b", 16'(ctl_b()), 16'(NORM));
        cyc(); #1;
        chk("postrst2_ctl_c", 16'(ctl_c()), 16'(NORM));
        chk("postrst2_cnt_b", ib.stall_cnt, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl_unit.md
HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

Interface
REQ-001 SHALL have parameter REG_W, default 5, meaning the register-index width.
REQ-002 SHALL have parameter LOAD_LAT, default 1, legal range 1..7, meaning the number of stall cycles inserted per load-use hazard.
REQ-003 SHALL have parameter CNT_W, default 16, meaning the stall performance counter width.
REQ-004 SHALL have clk  input  1  the single clock; all flops sample on the rising edge.
REQ-005 SHALL have reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have ID_EX_rd  input  REG_W  destination register of the instruction in EX.
REQ-007 SHALL have ID_EX_memread  input  1  the EX instruction is a load.
REQ-008 SHALL have IF_ID_rs1, IF_ID_rs2  input  REG_W each  source registers of the instruction in ID.
REQ-009 SHALL have IF_ID_rs1_used, IF_ID_rs2_used  input  1 each  the ID instruction actually reads that source.
REQ-010 SHALL have branch_taken  input  1  EX resolved a taken branch or jump; the PC is redirected this cycle.
REQ-011 SHALL have dmem_busy  input  1  data memory is not ready; the whole pipeline must freeze.
REQ-012 SHALL have perf_clr  input  1  synchronous clear of stall_cnt.
REQ-013 SHALL have PCWrite, IF_Dwrite  output  1 each  PC and IF/ID register write enables.
REQ-014 SHALL have hazard_out  output  1  inserts a bubble (zeroes control) into ID/EX.
REQ-015 SHALL have if_id_flush  output  1  invalidates the IF/ID register.
REQ-016 SHALL have pipe_freeze  output  1  holds ID/EX, EX/MEM and MEM/WB.
REQ-017 SHALL have stall_cnt  output  CNT_W  count of cycles with PCWrite=0.

Function
REQ-018 SHALL define hazard as ID_EX_memread AND ID_EX_rd!=0 AND ((rs1_used AND rd==rs1) OR (rs2_used AND rd==rs2)); register x0 or an unused source never causes a stall.
REQ-019 SHALL implement the FSM states IDLE and LSTALL, plus a 3-bit down-counter rem.
REQ-020 SHALL apply this priority each cycle: dmem_busy > branch_taken > LSTALL > hazard > normal.
REQ-021 SHALL, when dmem_busy=1, drive pipe_freeze=1, PCWrite=0, IF_Dwrite=0, hazard_out=0 and if_id_flush=0, with no change to state or rem.
REQ-022 SHALL, when branch_taken=1 (not busy), drive PCWrite=1, IF_Dwrite=1, if_id_flush=1 and hazard_out=1, and force state to IDLE, aborting any LSTALL.
REQ-023 SHALL, in IDLE with a hazard (not busy, no branch), drive PCWrite=0, IF_Dwrite=0 and hazard_out=1; if LOAD_LAT>1, go to LSTALL with rem=LOAD_LAT-2, else stay in IDLE.
REQ-024 SHALL, in LSTALL (not busy, no branch), drive PCWrite=0, IF_Dwrite=0 and hazard_out=1; if rem==0, go to IDLE, else decrement rem.
REQ-025 SHALL stall for exactly LOAD_LAT consecutive unfrozen cycles per hazard; frozen cycles extend the stall without consuming it.
REQ-026 SHALL, in the normal case, drive PCWrite=1, IF_Dwrite=1 and all other control outputs 0.
REQ-027 SHALL derive all control outputs combinationally from the inputs and the current state, with zero-cycle latency.
REQ-028 SHALL increment stall_cnt in every cycle with PCWrite=0, saturating at all-ones; perf_clr=1 loads 0 and takes precedence over the increment.

Reset
REQ-029 SHALL, while reset_n=0, asynchronously set state=IDLE, rem=0 and stall_cnt=0; outputs then read PCWrite=1, IF_Dwrite=1, others 0 (with dmem_busy and branch_taken low).
REQ-030 SHALL, when reset is asserted during LSTALL, abandon the stall immediately; the first cycle after release is IDLE.

Verification
REQ-031 SHALL cover: LOAD_LAT=1; ID_EX_memread=1, rd=5, rs1=5, rs1_used=1 -> one cycle with PCWrite=0, hazard_out=1; stall_cnt=1.
REQ-032 SHALL cover: LOAD_LAT=3, same hazard -> exactly 3 cycles with hazard_out=1, then PCWrite=1; stall_cnt=3.
REQ-033 SHALL cover: rd=0 with rs1=0, or rd=7 with rs2=7 and rs2_used=0 -> no stall; PCWrite stays 1.
REQ-034 SHALL cover: LOAD_LAT=3, dmem_busy=1 for 2 cycles inside LSTALL -> pipe_freeze=1 for those 2 cycles, total 5 cycles with PCWrite=0; stall_cnt=5.
REQ-035 SHALL cover: branch_taken=1 in the 2nd LSTALL cycle -> if_id_flush=1 and PCWrite=1 that cycle, IDLE next cycle; branch_taken with dmem_busy=1 -> flush suppressed until busy drops.
REQ-036 SHALL cover: CNT_W=4, 20 stall cycles -> stall_cnt saturates at 15; perf_clr=1 -> 0; reset_n=0 mid-LSTALL -> outputs at reset values the same cycle.
